l2_ctrl_fsm: RTL and testbench

Command sequencer for the split L2 cache.
- Accepts one trace-style command (L1 data read/write, L1 instruction read, snooped requests, clear, print) at a time.
- Performs the tag/MESI lookup on the cache state array and decides hit or miss.
- Drives victim writeback and fill bus operations, then writes back the new tag/MESI/LRU state.
- Sits between the trace/command front end, the tag/state array and the system-bus model.

---
 rtl/l2_ctrl_fsm.sv | 175 +++++++++++++++++
 tb/tb_l2_ctrl_fsm.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/l2_ctrl_fsm.sv
// l2_ctrl_fsm: split-L2 command sequencer; ports: cmd_* command in, lk_*/vic_* tag lookup, upd_*/lru_touch_o state write, bus_* system bus, snp_* snoop reply, print_req_o, *_cnt_o saturating stats
module l2_ctrl_fsm #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 6,
  parameter int INDEX_W  = 14,
  parameter int WAY_W    = 3,
  parameter int CNT_W    = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 cmd_valid_i,
  output logic                                 cmd_ready_o,
  input  logic [3:0]                           cmd_i,
  input  logic [ADDR_W-1:0]                    cmd_addr_i,
  output logic                                 lk_req_o,
  output logic [INDEX_W-1:0]                   lk_index_o,
  output logic [ADDR_W-INDEX_W-OFFSET_W-1:0]   lk_tag_o,
  input  logic                                 lk_hit_i,
  input  logic [WAY_W-1:0]                     lk_way_i,
  input  logic [1:0]                           lk_mesi_i,
  input  logic [WAY_W-1:0]                     vic_way_i,
  input  logic [ADDR_W-INDEX_W-OFFSET_W-1:0]   vic_tag_i,
  input  logic [1:0]                           vic_mesi_i,
  output logic                                 upd_we_o,
  output logic [INDEX_W-1:0]                   upd_index_o,
  output logic [WAY_W-1:0]                     upd_way_o,
  output logic [ADDR_W-INDEX_W-OFFSET_W-1:0]   upd_tag_o,
  output logic [1:0]                           upd_mesi_o,
  output logic                                 lru_touch_o,
  output logic                                 bus_req_o,
  output logic [2:0]                           bus_op_o,
  output logic [ADDR_W-1:0]                    bus_addr_o,
  input  logic                                 bus_done_i,
  input  logic [1:0]                           bus_snoop_i,
  output logic                                 snp_valid_o,
  output logic [1:0]                           snp_res_o,
  output logic                                 print_req_o,
  output logic [CNT_W-1:0]                     hit_cnt_o,
  output logic [CNT_W-1:0]                     miss_cnt_o,
  output logic [CNT_W-1:0]                     rd_cnt_o,
  output logic [CNT_W-1:0]                     wr_cnt_o
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  typedef enum logic [2:0] {IDLE, LOOKUP, DECIDE, WB, FILL, INV, UPDATE, CLEAR} state_t;
  state_t state_q;
  logic [3:0] cmd_q;
  logic [INDEX_W-1:0] lk_index_q, upd_index_q;
  logic [TAG_W-1:0] lk_tag_q, upd_tag_q;
  logic [WAY_W-1:0] upd_way_q;
  logic [1:0] upd_mesi_q, snp_res_q, snp_d;
  logic lk_req_q, upd_we_q, lru_touch_q, bus_req_q, snp_valid_q, print_req_q;
  logic [2:0] bus_op_q;
  logic [ADDR_W-1:0] bus_addr_q, line, vic_line;
  logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q, rd_cnt_q, wr_cnt_q;
  logic l1, wr, hit, unused_ok;
  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] x);
    return x + CNT_W'(~&x);
  endfunction
  assign unused_ok = ^cmd_addr_i[OFFSET_W-1:0];
  assign l1 = cmd_q < 4'd3;
  assign wr = cmd_q == 4'd1;
  assign hit = lk_hit_i && lk_mesi_i != 2'd0;
  assign line = {lk_tag_q, lk_index_q, {OFFSET_W{1'b0}}};
  assign vic_line = {vic_tag_i, lk_index_q, {OFFSET_W{1'b0}}};
  always_comb snp_d = !hit ? 2'd2 : cmd_q == 4'd6 ? (lk_mesi_i == 2'd1 ? 2'd0 : 2'd2) : lk_mesi_i == 2'd3 ? 2'd1 : 2'd0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      {cmd_q, lk_index_q, lk_tag_q, upd_index_q, upd_tag_q, upd_way_q, upd_mesi_q, snp_res_q} <= '0;
      {lk_req_q, upd_we_q, lru_touch_q, bus_req_q, snp_valid_q, print_req_q, bus_op_q, bus_addr_q} <= '0;
      {hit_cnt_q, miss_cnt_q, rd_cnt_q, wr_cnt_q} <= '0;
    end else begin
      lk_req_q <= 1'b0;
      snp_valid_q <= 1'b0;
      print_req_q <= 1'b0;
      case (state_q)
        IDLE: if (cmd_valid_i) begin
          cmd_q <= cmd_i;
          lk_index_q <= cmd_addr_i[OFFSET_W +: INDEX_W];
          lk_tag_q <= cmd_addr_i[ADDR_W-1 -: TAG_W];
          if (cmd_i == 4'd8) begin
            state_q <= CLEAR;
            upd_we_q <= 1'b1;
            lru_touch_q <= 1'b0;
            {upd_index_q, upd_way_q, upd_tag_q, upd_mesi_q} <= '0;
            {hit_cnt_q, miss_cnt_q, rd_cnt_q, wr_cnt_q} <= '0;
          end else if (cmd_i == 4'd9) print_req_q <= 1'b1;
          else if (cmd_i < 4'd7) begin
            state_q <= LOOKUP;
            lk_req_q <= 1'b1;
          end
        end
        LOOKUP: state_q <= DECIDE;
        DECIDE: begin
          upd_index_q <= lk_index_q;
          upd_tag_q <= lk_tag_q;
          upd_way_q <= hit ? lk_way_i : vic_way_i;
          state_q <= IDLE;
          if (l1) begin
            if (hit) hit_cnt_q <= inc(hit_cnt_q); else miss_cnt_q <= inc(miss_cnt_q);
            if (wr) wr_cnt_q <= inc(wr_cnt_q); else rd_cnt_q <= inc(rd_cnt_q);
            if (hit && !(wr && lk_mesi_i == 2'd1)) begin
              state_q <= UPDATE;
              upd_we_q <= 1'b1;
              lru_touch_q <= 1'b1;
              upd_mesi_q <= wr ? 2'd3 : lk_mesi_i;
            end else begin
              bus_req_q <= 1'b1;
              upd_mesi_q <= 2'd3;
              state_q <= hit ? INV : vic_mesi_i == 2'd3 ? WB : FILL;
              bus_op_q <= hit ? 3'd3 : vic_mesi_i == 2'd3 ? 3'd2 : wr ? 3'd4 : 3'd1;
              bus_addr_q <= (!hit && vic_mesi_i == 2'd3) ? vic_line : line;
            end
          end else if (cmd_q != 4'd4) begin
            snp_valid_q <= 1'b1;
            snp_res_q <= snp_d;
            upd_mesi_q <= cmd_q == 4'd3 ? 2'd1 : 2'd0;
            if (snp_d == 2'd1) begin
              state_q <= WB;
              bus_req_q <= 1'b1;
              bus_op_q <= 3'd2;
              bus_addr_q <= line;
            end else if (snp_d == 2'd0) begin
              state_q <= UPDATE;
              upd_we_q <= 1'b1;
            end
          end
        end
        WB, FILL, INV: if (bus_req_q && bus_done_i) begin
          // bus_req always drops for a cycle, even when chaining WB into FILL
          bus_req_q <= 1'b0;
          if (state_q == WB && l1) begin
            state_q <= FILL;
            bus_op_q <= wr ? 3'd4 : 3'd1;
            bus_addr_q <= line;
          end else begin
            state_q <= UPDATE;
            upd_we_q <= 1'b1;
            lru_touch_q <= l1;
            if (state_q == FILL && !wr) upd_mesi_q <= bus_snoop_i == 2'd2 ? 2'd2 : 2'd1;
          end
        end else bus_req_q <= 1'b1;
        UPDATE: begin
          upd_we_q <= 1'b0;
          lru_touch_q <= 1'b0;
          state_q <= IDLE;
        end
        CLEAR: if (&{upd_index_q, upd_way_q}) begin
          upd_we_q <= 1'b0;
          state_q <= IDLE;
        end else {upd_index_q, upd_way_q} <= {upd_index_q, upd_way_q} + 1'b1;
      endcase
    end
  end
  assign cmd_ready_o = state_q == IDLE;
  assign lk_req_o = lk_req_q;
  assign lk_index_o = lk_index_q;
  assign lk_tag_o = lk_tag_q;
  assign upd_we_o = upd_we_q;
  assign upd_index_o = upd_index_q;
  assign upd_way_o = upd_way_q;
  assign upd_tag_o = upd_tag_q;
  assign upd_mesi_o = upd_mesi_q;
  assign lru_touch_o = lru_touch_q;
  assign bus_req_o = bus_req_q;
  assign bus_op_o = bus_op_q;
  assign bus_addr_o = bus_addr_q;
  assign snp_valid_o = snp_valid_q;
  assign snp_res_o = snp_res_q;
  assign print_req_o = print_req_q;
  assign hit_cnt_o = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
endmodule

// File: tb/tb_l2_ctrl_fsm.sv
// tb_l2_ctrl_fsm: scoreboard bench for l2_ctrl_fsm with a small cache geometry and 4-bit counters
module tb_l2_ctrl_fsm;
  localparam int TW = 24;
  logic clk = 0, rst_n = 0;
  logic cmd_valid = 0, cmd_ready;
  logic [3:0] cmd = 0;
  logic [31:0] cmd_addr = 0;
  logic lk_req, lk_hit = 0, lk_way = 0, vic_way = 0;
  logic [1:0] lk_index, lk_mesi = 0, vic_mesi = 0;
  logic [TW-1:0] lk_tag, vic_tag = 0, upd_tag;
  logic upd_we, upd_way, lru_touch, bus_req, bus_done = 0, snp_valid, print_req;
  logic [1:0] upd_index, upd_mesi, bus_snoop = 2, snp_res;
  logic [2:0] bus_op;
  logic [31:0] bus_addr;
  logic [3:0] hit_cnt, miss_cnt, rd_cnt, wr_cnt;
  logic hold_bus = 0;
  int bus_lat = 2, n_cmp = 0, n_err = 0, lat, n;
  logic [63:0] sb[$];
  l2_ctrl_fsm #(.INDEX_W(2), .WAY_W(1), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_i(cmd),
    .cmd_addr_i(cmd_addr), .lk_req_o(lk_req), .lk_index_o(lk_index), .lk_tag_o(lk_tag),
    .lk_hit_i(lk_hit), .lk_way_i(lk_way), .lk_mesi_i(lk_mesi), .vic_way_i(vic_way),
    .vic_tag_i(vic_tag), .vic_mesi_i(vic_mesi), .upd_we_o(upd_we), .upd_index_o(upd_index),
    .upd_way_o(upd_way), .upd_tag_o(upd_tag), .upd_mesi_o(upd_mesi), .lru_touch_o(lru_touch),
    .bus_req_o(bus_req), .bus_op_o(bus_op), .bus_addr_o(bus_addr), .bus_done_i(bus_done),
    .bus_snoop_i(bus_snoop), .snp_valid_o(snp_valid), .snp_res_o(snp_res),
    .print_req_o(print_req), .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt), .rd_cnt_o(rd_cnt),
    .wr_cnt_o(wr_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] ev_lk(logic [TW-1:0] t, logic [1:0] i);
    return {4'h5, 34'd0, t, i};
  endfunction
  function automatic logic [63:0] ev_snp(logic [1:0] r);
    return {4'h1, 58'd0, r};
  endfunction
  function automatic logic [63:0] ev_bus(logic [2:0] op, logic [31:0] a);
    return {4'h2, 25'd0, op, a};
  endfunction
  function automatic logic [63:0] ev_upd(logic lru, logic [1:0] m, logic [TW-1:0] t, logic w, logic [1:0] i);
    return {4'h3, 30'd0, lru, m, t, w, i};
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic pop_cmp(input string tag, input logic [63:0] got);
    if (sb.size() == 0) check({tag, "_unexpected"}, got, 64'd0);
    else check(tag, got, sb.pop_front());
  endtask
  always @(negedge clk) if (rst_n) begin
    if (lk_req) pop_cmp("lk", ev_lk(lk_tag, lk_index));
    if (snp_valid) pop_cmp("snp", ev_snp(snp_res));
    if (bus_req && bus_done) pop_cmp("bus", ev_bus(bus_op, bus_addr));
    if (upd_we) pop_cmp("upd", ev_upd(lru_touch, upd_mesi, upd_tag, upd_way, upd_index));
    if (print_req) pop_cmp("print", {4'h4, 60'd0});
  end
  initial forever begin
    @(posedge clk); #1;
    if (bus_req && !hold_bus) begin
      repeat (bus_lat) begin @(posedge clk); #1; end
      bus_done = 1;
      @(posedge clk); #1;
      bus_done = 0;
    end
  end
  task automatic issue(input logic [3:0] c, input logic [31:0] a);
    int k = 0;
    while (!cmd_ready && k < 100) begin @(negedge clk); k++; end
    @(negedge clk);
    cmd_valid = 1; cmd = c; cmd_addr = a;
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask
  task automatic do_cmd(input logic [3:0] c, input logic [31:0] a, output int l);
    issue(c, a);
    l = 0;
    do begin @(negedge clk); l++; end while (!cmd_ready && l < 500);
    if (l >= 500) check("timeout", 64'(l), 64'd0);
  endtask
  task automatic lookup(input logic h, input logic [1:0] m, input logic w, input logic [1:0] vm, input logic vw, input logic [TW-1:0] vt);
    lk_hit = h; lk_mesi = m; lk_way = w; vic_mesi = vm; vic_way = vw; vic_tag = vt;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_out", {upd_we, lk_req, bus_req, snp_valid, print_req, lru_touch, bus_op, bus_addr}, 64'd0);
    check("rst_ready", 64'(cmd_ready), 64'd1);
    check("rst_cnt", {hit_cnt, miss_cnt, rd_cnt, wr_cnt}, 64'd0);
    rst_n = 1;
    // L1DR miss, empty set, no other sharer -> E
    lookup(0, 0, 0, 0, 1, 0); bus_snoop = 2;
    sb.push_back(ev_lk(24'h10, 1)); sb.push_back(ev_bus(1, 32'h1040)); sb.push_back(ev_upd(1, 2, 24'h10, 1, 1));
    do_cmd(0, 32'h1040, lat);
    check("miss_cnt1", 64'(miss_cnt), 64'd1);
    check("rd_cnt1", 64'(rd_cnt), 64'd1);
    // L1DR hit in E
    lookup(1, 2, 1, 0, 0, 0);
    sb.push_back(ev_lk(24'h10, 1)); sb.push_back(ev_upd(1, 2, 24'h10, 1, 1));
    do_cmd(0, 32'h1040, lat);
    check("hit_lat", 64'(lat), 64'd4);
    check("hit_cnt1", 64'(hit_cnt), 64'd1);
    // L1DW hit in S -> INVALIDATE then M
    lookup(1, 1, 0, 0, 1, 0);
    sb.push_back(ev_lk(24'h20, 2)); sb.push_back(ev_bus(3, 32'h2080)); sb.push_back(ev_upd(1, 3, 24'h20, 0, 2));
    do_cmd(1, 32'h2080, lat);
    // L1DW miss, victim M tag 3 -> WRITE victim, RWIM, M
    lookup(0, 0, 0, 3, 1, 24'h3);
    sb.push_back(ev_lk(24'h50, 3)); sb.push_back(ev_bus(2, 32'h3C0)); sb.push_back(ev_bus(4, 32'h50C0));
    sb.push_back(ev_upd(1, 3, 24'h50, 1, 3));
    do_cmd(1, 32'h50C0, lat);
    // L1IR miss, victim E, another cache has it -> S
    lookup(0, 0, 0, 2, 0, 24'h7); bus_snoop = 0;
    sb.push_back(ev_lk(24'h1, 0)); sb.push_back(ev_bus(1, 32'h100)); sb.push_back(ev_upd(1, 1, 24'h1, 0, 0));
    do_cmd(2, 32'h100, lat);
    check("cnt_l1", {hit_cnt, miss_cnt, rd_cnt, wr_cnt}, 64'h2332);
    // SRREQ on M -> HITM, WRITE, S
    lookup(1, 3, 1, 0, 0, 0);
    sb.push_back(ev_lk(24'h10, 1)); sb.push_back(ev_snp(1)); sb.push_back(ev_bus(2, 32'h1040));
    sb.push_back(ev_upd(0, 1, 24'h10, 1, 1));
    do_cmd(3, 32'h1040, lat);
    // SRFO on E -> HIT, I
    lookup(1, 2, 0, 0, 1, 0);
    sb.push_back(ev_lk(24'h20, 2)); sb.push_back(ev_snp(0)); sb.push_back(ev_upd(0, 0, 24'h20, 0, 2));
    do_cmd(5, 32'h2080, lat);
    // SIREQ miss -> NOHIT, no update
    lookup(0, 0, 0, 3, 1, 24'h9);
    sb.push_back(ev_lk(24'h50, 3)); sb.push_back(ev_snp(2));
    do_cmd(6, 32'h50C0, lat);
    // SIREQ on E -> NOHIT, no update
    lookup(1, 2, 1, 0, 0, 0);
    sb.push_back(ev_lk(24'h10, 1)); sb.push_back(ev_snp(2));
    do_cmd(6, 32'h1040, lat);
    // SWREQ -> lookup only
    lookup(1, 3, 1, 0, 0, 0);
    sb.push_back(ev_lk(24'h10, 1));
    do_cmd(4, 32'h1040, lat);
    check("cnt_snoop", {hit_cnt, miss_cnt, rd_cnt, wr_cnt}, 64'h2332);
    sb.push_back({4'h4, 60'd0});
    do_cmd(9, 0, lat);
    check("print_lat", 64'(lat), 64'd1);
    do_cmd(7, 32'h1040, lat);
    check("unk_lat", 64'(lat), 64'd1);
    // CCLR sweeps 4 sets x 2 ways, index-major
    for (int i = 0; i < 4; i++)
      for (int w = 0; w < 2; w++) sb.push_back(ev_upd(0, 0, 0, w[0], i[1:0]));
    do_cmd(8, 32'hFFFF_FFFF, lat);
    check("clr_lat", 64'(lat), 64'd9);
    check("clr_cnt", {hit_cnt, miss_cnt, rd_cnt, wr_cnt}, 64'd0);
    // reset while waiting on bus_done
    hold_bus = 1;
    lookup(0, 0, 0, 0, 1, 0);
    sb.push_back(ev_lk(24'h10, 1));
    issue(0, 32'h1040);
    n = 0;
    while (!bus_req && n < 20) begin @(negedge clk); n++; end
    check("bus_wait", 64'(bus_req), 64'd1);
    repeat (2) @(negedge clk);
    #2 rst_n = 0;
    #1 check("rst_mid_out", {upd_we, lk_req, bus_req, snp_valid, print_req, lru_touch, bus_op, bus_addr}, 64'd0);
    check("rst_mid_cnt", {hit_cnt, miss_cnt, rd_cnt, wr_cnt}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1; hold_bus = 0;
    @(negedge clk);
    check("rst_mid_ready", 64'(cmd_ready), 64'd1);
    // counters saturate at all-ones
    lookup(1, 2, 0, 0, 0, 0);
    for (int k = 0; k < 17; k++) begin
      sb.push_back(ev_lk(24'h1, 0)); sb.push_back(ev_upd(1, 2, 24'h1, 0, 0));
      do_cmd(2, 32'h100, lat);
      if (k == 14) check("hit_cnt15", 64'(hit_cnt), 64'hF);
    end
    check("hit_sat", 64'(hit_cnt), 64'hF);
    check("rd_sat", 64'(rd_cnt), 64'hF);
    check("miss_hold", 64'(miss_cnt), 64'd0);
    repeat (5) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
